// File: rtl/counter_seq_monitor.sv
// counter_seq_monitor: receive-side checker for a ring / Johnson counter pair.
// Both buses are decoded to a state index on every rising edge. One lock FSM
// per counter tracks the sequence. Once a counter is locked, any bad step
// raises a one-cycle error pulse, and the pulse is added to a shared
// saturating error count.

// Per-counter lock tracker.
// It registers the decoded index and valid flag, and walks IDLE -> TRACK ->
// LOCKED on consecutive +1 (mod MODN) steps. A bad step taken from LOCKED
// raises err.
module counter_seq_tracker #(
  parameter int MODN     = 4,
  parameter int IDX_W    = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             code_valid,
  input  logic [IDX_W-1:0] code_idx,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             lock,
  output logic             err,
  output logic             err_set
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_LOCKED
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MODN - 1);
  localparam logic [3:0]       LOCK_VAL = 4'(LOCK_CNT);

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       good_q;
  logic [3:0]       good_d;
  logic [3:0]       good_inc;
  logic [IDX_W-1:0] exp_idx;
  logic             good_step;

  // Expected successor of the last legal index, with wrap at MODN-1.
  assign exp_idx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  assign good_step = code_valid && (code_idx == exp_idx);
  assign good_inc  = good_q + 4'd1;

  // Next-state logic: lock after LOCK_CNT good steps; break on any bad step.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    good_d  = good_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (code_valid) begin
          state_d = S_TRACK;
          good_d  = '0;
        end
      end
      S_TRACK: begin
        if (good_step) begin
          good_d = good_inc;
          if (good_inc == LOCK_VAL) state_d = S_LOCKED;
        end else if (code_valid) begin
          good_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (!good_step) begin
          err_set = 1'b1;
          good_d  = '0;
          state_d = code_valid ? S_TRACK : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and registered outputs. An illegal code leaves idx holding
  // the last legal index, which is also the reference for the next step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      good_q  <= '0;
      idx     <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here see the
      // pre-edge values of the others, whatever order the lines are in.
      state_q <= state_d;
      good_q  <= good_d;
      valid   <= code_valid;
      err     <= err_set;
      if (code_valid) idx <= code_idx;
    end
  end

  assign lock = (state_q == S_LOCKED);

endmodule

// Top level: decoders, two trackers and the shared saturating error counter.
module counter_seq_monitor #(
  parameter int W        = 4,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [W-1:0]            qr,
  input  logic [W-1:0]            qj,
  output logic [$clog2(W)-1:0]    ring_idx,
  output logic [$clog2(2*W)-1:0]  john_idx,
  output logic                    ring_valid,
  output logic                    john_valid,
  output logic                    ring_lock,
  output logic                    john_lock,
  output logic                    ring_err,
  output logic                    john_err,
  output logic [ERR_W-1:0]        err_cnt
);

  localparam int              RW   = $clog2(W);
  localparam int              JW   = $clog2(2 * W);
  localparam int              EW1  = ERR_W + 1;
  localparam logic [W-1:0]    ONES = '1;
  localparam logic [EW1-1:0]  EMAX = {1'b0, {ERR_W{1'b1}}};

  logic          ring_dec_valid;
  logic [RW-1:0] ring_dec_idx;
  logic          john_dec_valid;
  logic [JW-1:0] john_dec_idx;
  logic          ring_err_set;
  logic          john_err_set;
  logic [EW1-1:0] err_sum;

  // Ring decode: only one-hot codes are legal; the index is the bit position.
  always_comb begin
    ring_dec_valid = 1'b0;
    ring_dec_idx   = '0;
    for (int i = 0; i < W; i++) begin
      if (qr == (W'(1) << i)) begin
        ring_dec_valid = 1'b1;
        ring_dec_idx   = RW'(i);
      end
    end
  end

  // Johnson decode: indices 0..W fill ones from the LSB; indices W+1..2W-1
  // shift the all-ones pattern left and clear the low bits.
  always_comb begin
    john_dec_valid = 1'b0;
    john_dec_idx   = '0;
    for (int i = 0; i <= W; i++) begin
      if (qj == W'((1 << i) - 1)) begin
        john_dec_valid = 1'b1;
        john_dec_idx   = JW'(i);
      end
    end
    for (int k = 1; k < W; k++) begin
      if (qj == (ONES << k)) begin
        john_dec_valid = 1'b1;
        john_dec_idx   = JW'(W + k);
      end
    end
  end

  counter_seq_tracker #(
    .MODN    (W),
    .IDX_W   (RW),
    .LOCK_CNT(LOCK_CNT)
  ) u_ring (
    .clk       (clk),
    .rst_n     (reset),
    .code_valid(ring_dec_valid),
    .code_idx  (ring_dec_idx),
    .idx       (ring_idx),
    .valid     (ring_valid),
    .lock      (ring_lock),
    .err       (ring_err),
    .err_set   (ring_err_set)
  );

  counter_seq_tracker #(
    .MODN    (2 * W),
    .IDX_W   (JW),
    .LOCK_CNT(LOCK_CNT)
  ) u_john (
    .clk       (clk),
    .rst_n     (reset),
    .code_valid(john_dec_valid),
    .code_idx  (john_dec_idx),
    .idx       (john_idx),
    .valid     (john_valid),
    .lock      (john_lock),
    .err       (john_err),
    .err_set   (john_err_set)
  );

  // The count is updated on the same edge that raises the error pulses, so it
  // already includes them in the cycle where they are visible. The sum is one
  // bit wider, so a double error near the top saturates instead of wrapping.
  assign err_sum = {1'b0, err_cnt} + EW1'(ring_err_set) + EW1'(john_err_set);

  // Saturating locked-state error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (err_sum > EMAX) begin
      err_cnt <= '1;
    end else begin
      err_cnt <= err_sum[ERR_W-1:0];
    end
  end

endmodule

// File: tb/tb_counter_seq_monitor.sv
// Self-checking bench for counter_seq_monitor.
// Two instances share the stimulus: one with an 8-bit error count and one with
// a 2-bit error count, so the second one shows saturation. The bench's own
// model pushes the expected outputs for each stimulus step to a queue. The
// DUT outputs are popped and compared 1 ns after the sampling edge.
module tb_counter_seq_monitor;

  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] qr;
  logic [3:0] qj;

  logic [1:0] ring_idx,   s_ring_idx;
  logic [2:0] john_idx,   s_john_idx;
  logic       ring_valid, s_ring_valid;
  logic       john_valid, s_john_valid;
  logic       ring_lock,  s_ring_lock;
  logic       john_lock,  s_john_lock;
  logic       ring_err,   s_ring_err;
  logic       john_err,   s_john_err;
  logic [7:0] err_cnt;
  logic [1:0] s_err_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  counter_seq_monitor #(.W(4), .LOCK_CNT(LOCK), .ERR_W(8)) u_dut (
    .clk(clk), .reset(reset), .qr(qr), .qj(qj),
    .ring_idx(ring_idx), .john_idx(john_idx),
    .ring_valid(ring_valid), .john_valid(john_valid),
    .ring_lock(ring_lock), .john_lock(john_lock),
    .ring_err(ring_err), .john_err(john_err),
    .err_cnt(err_cnt)
  );

  counter_seq_monitor #(.W(4), .LOCK_CNT(LOCK), .ERR_W(2)) u_sat (
    .clk(clk), .reset(reset), .qr(qr), .qj(qj),
    .ring_idx(s_ring_idx), .john_idx(s_john_idx),
    .ring_valid(s_ring_valid), .john_valid(s_john_valid),
    .ring_lock(s_ring_lock), .john_lock(s_john_lock),
    .ring_err(s_ring_err), .john_err(s_john_err),
    .err_cnt(s_err_cnt)
  );

  // Reference code tables.
  logic [3:0] rc [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] jc [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                         4'b1111, 4'b1110, 4'b1100, 4'b1000};

  // Model state: st 0=IDLE, 1=TRACK, 2=LOCKED.
  typedef struct {
    int st;
    int gcnt;
    int idx;
    bit vld;
    bit err;
  } trk_t;

  typedef struct {
    int ridx;
    int jidx;
    bit rv;
    bit jv;
    bit rl;
    bit jl;
    bit re;
    bit je;
    int ec8;
    int ec2;
  } exp_t;

  trk_t rm = '{default: 0};
  trk_t jm = '{default: 0};
  int   tot = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int ring_dec(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (c === rc[i]) return i;
    return -1;
  endfunction

  function automatic int john_dec(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (c === jc[i]) return i;
    return -1;
  endfunction

  function automatic trk_t trk_next(input trk_t s, input int ci, input int modn);
    trk_t n;
    bit   legal;
    bit   good;
    legal = (ci >= 0);
    good  = legal && (ci == (s.idx + 1) % modn);
    n     = s;
    n.err = 1'b0;
    n.vld = legal;
    if (legal) n.idx = ci;
    case (s.st)
      0: if (legal) begin n.st = 1; n.gcnt = 0; end
      1: begin
        if (good) begin
          n.gcnt = s.gcnt + 1;
          if (n.gcnt == LOCK) n.st = 2;
        end else if (legal) begin
          n.gcnt = 0;
        end else begin
          n.st = 0;
        end
      end
      default: begin
        if (!good) begin
          n.err  = 1'b1;
          n.gcnt = 0;
          n.st   = legal ? 1 : 0;
        end
      end
    endcase
    return n;
  endfunction

  task automatic model_reset();
    rm  = '{default: 0};
    jm  = '{default: 0};
    tot = 0;
  endtask

  task automatic compare_out();
    exp_t e;
    n_asserts++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    check("ring_idx",   32'(ring_idx),   e.ridx);
    check("john_idx",   32'(john_idx),   e.jidx);
    check("ring_valid", 32'(ring_valid), 32'(e.rv));
    check("john_valid", 32'(john_valid), 32'(e.jv));
    check("ring_lock",  32'(ring_lock),  32'(e.rl));
    check("john_lock",  32'(john_lock),  32'(e.jl));
    check("ring_err",   32'(ring_err),   32'(e.re));
    check("john_err",   32'(john_err),   32'(e.je));
    check("err_cnt",    32'(err_cnt),    e.ec8);
    check("sat_ring_idx",  32'(s_ring_idx),  e.ridx);
    check("sat_john_idx",  32'(s_john_idx),  e.jidx);
    check("sat_valid",     32'({s_ring_valid, s_john_valid}), 32'({e.rv, e.jv}));
    check("sat_lock",      32'({s_ring_lock, s_john_lock}),   32'({e.rl, e.jl}));
    check("sat_err",       32'({s_ring_err, s_john_err}),     32'({e.re, e.je}));
    check("sat_err_cnt",   32'(s_err_cnt),   e.ec2);
  endtask

  // One sample: drive the buses, predict the outputs, then compare after the edge.
  task automatic step(input logic [3:0] r, input logic [3:0] j);
    exp_t e;
    qr  = r;
    qj  = j;
    rm  = trk_next(rm, ring_dec(r), 4);
    jm  = trk_next(jm, john_dec(j), 8);
    tot = tot + int'(rm.err) + int'(jm.err);
    e.ridx = rm.idx;
    e.jidx = jm.idx;
    e.rv   = rm.vld;
    e.jv   = jm.vld;
    e.rl   = (rm.st == 2);
    e.jl   = (jm.st == 2);
    e.re   = rm.err;
    e.je   = jm.err;
    e.ec8  = (tot > 255) ? 255 : tot;
    e.ec2  = (tot > 3) ? 3 : tot;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_idx"},   32'({ring_idx, john_idx, s_ring_idx, s_john_idx}), 32'd0);
    check({tag, "_valid"}, 32'({ring_valid, john_valid, s_ring_valid, s_john_valid}), 32'd0);
    check({tag, "_lock"},  32'({ring_lock, john_lock, s_ring_lock, s_john_lock}), 32'd0);
    check({tag, "_err"},   32'({ring_err, john_err, s_ring_err, s_john_err}), 32'd0);
    check({tag, "_cnt"},   32'({err_cnt, s_err_cnt}), 32'd0);
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    qr    = 4'b0001;
    qj    = 4'b0000;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // Clean sequences from reset release; the release sample is the first one.
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(rc[i % 4], jc[i % 8]);
      if (i == 3) check("lock_not_yet", 32'({ring_lock, john_lock}), 32'd0);
      if (i == 4) check("lock_after_5", 32'({ring_lock, john_lock}), 32'b11);
    end
    check("clean_err_cnt", 32'(err_cnt), 32'd0);

    // Illegal ring code while locked, then resume and re-lock.
    step(4'b0011, jc[4]);
    check("ring_illegal_valid", 32'(ring_valid), 32'd0);
    check("ring_illegal_err",   32'({ring_err, ring_lock}), 32'b10);
    check("ring_illegal_cnt",   32'(err_cnt), 32'd1);
    step(rc[2], jc[5]);
    step(rc[3], jc[6]);
    step(rc[0], jc[7]);
    step(rc[1], jc[0]);
    check("ring_relock_3", 32'(ring_lock), 32'd0);
    step(rc[2], jc[1]);
    check("ring_relock_4", 32'({ring_lock, john_lock}), 32'b11);

    // Johnson skip 0011 -> 1111 while locked.
    step(rc[3], jc[2]);
    step(rc[0], jc[4]);
    check("john_skip_err",  32'({john_err, john_lock}), 32'b10);
    check("john_skip_idx",  32'(john_idx), 32'd4);
    check("john_skip_cnt",  32'(err_cnt), 32'd2);
    step(rc[1], jc[5]);
    step(rc[2], jc[6]);
    step(rc[3], jc[7]);
    step(rc[0], jc[0]);
    check("john_relock", 32'(john_lock), 32'd1);

    // Stall both: double error; the 2-bit counter goes from 2 to 3.
    step(rc[0], jc[0]);
    check("stall_both_err", 32'({ring_err, john_err}), 32'b11);
    check("stall_cnt8",     32'(err_cnt), 32'd4);
    check("stall_cnt2_sat", 32'(s_err_cnt), 32'd3);
    for (int i = 1; i <= 4; i++) step(rc[i % 4], jc[i]);
    step(rc[0], jc[4]);
    check("stall2_cnt8", 32'(err_cnt), 32'd6);
    check("stall2_sat",  32'(s_err_cnt), 32'd3);
    for (int i = 1; i <= 4; i++) step(rc[i % 4], jc[(i + 4) % 8]);
    check("both_locked", 32'({ring_lock, john_lock}), 32'b11);

    // Asynchronous reset between edges while both counters are locked.
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step(rc[i % 4], jc[i]);
    check("relock_after_reset", 32'({ring_lock, john_lock}), 32'b11);
    check("cnt_after_reset",    32'(err_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
